// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: sequential instruction fetch front end with a DEPTH-entry
// fetch queue, stall-aware I-cache handshake and redirect flush/kill handling.
// Optional performance counters are enabled by defining FETCH_PERF_EN.
module fetch_queue_unit #(
    parameter int ADDR_W   = 30,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 4,
    parameter int RESET_PC = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic                       I_ren,
    output logic [ADDR_W-1:0]          I_addr,
    input  logic                       I_stall,
    input  logic [DATA_W-1:0]          I_rdata,
    input  logic                       redirect_valid,
    input  logic [ADDR_W-1:0]          redirect_addr,
    input  logic                       id_ready,
    output logic                       if_valid,
    output logic [DATA_W-1:0]          if_instr,
    output logic [ADDR_W-1:0]          if_pc,
    output logic [$clog2(DEPTH):0]     queue_count,
    output logic [31:0]                perf_stall_cycles,
    output logic [15:0]                perf_redirects
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {BOOT, RUN, KILL} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   fetch_pc;
    logic [ADDR_W-1:0]   target;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    count_nxt;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic                completion;
    logic                push;
    logic                pop;

    logic [DATA_W-1:0]   instr_mem [DEPTH];
    logic [ADDR_W-1:0]   pc_mem    [DEPTH];

    assign I_addr      = fetch_pc;
    assign queue_count = count;
    assign if_valid    = (count != '0);
    assign if_instr    = if_valid ? instr_mem[rd_ptr] : '0;
    assign if_pc       = if_valid ? pc_mem[rd_ptr] : '0;

    // Handshake decode: redirect overrides both push and pop.
    always_comb begin
        completion = I_ren && !I_stall;
        push       = (state == RUN) && completion && !redirect_valid;
        pop        = if_valid && id_ready && !redirect_valid;
        count_nxt  = count;
        if (redirect_valid)
            count_nxt = '0;
        else if (push && !pop)
            count_nxt = count + CNT_W'(1);
        else if (pop && !push)
            count_nxt = count - CNT_W'(1);
    end

    // Fetch control FSM with registered request outputs and queue bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BOOT;
            fetch_pc <= ADDR_W'(RESET_PC);
            target   <= '0;
            I_ren    <= 1'b0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            count <= count_nxt;
            if (redirect_valid) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case (state)
                BOOT: begin
                    state <= RUN;
                    I_ren <= 1'b1;
                    if (redirect_valid) fetch_pc <= redirect_addr;
                end
                RUN: begin
                    if (redirect_valid) begin
                        // A stalled request cannot be withdrawn: keep it on the bus
                        // and swallow its response in KILL before refetching.
                        if (I_ren && I_stall) begin
                            state  <= KILL;
                            target <= redirect_addr;
                        end else begin
                            fetch_pc <= redirect_addr;
                        end
                        I_ren <= 1'b1;
                    end else begin
                        if (push) fetch_pc <= fetch_pc + ADDR_W'(1);
                        I_ren <= (count_nxt < FULL);
                    end
                end
                KILL: begin
                    I_ren <= 1'b1;
                    if (completion) begin
                        state    <= RUN;
                        fetch_pc <= redirect_valid ? redirect_addr : target;
                    end else if (redirect_valid) begin
                        target <= redirect_addr;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

    // Queue storage write port; contents are qualified by count, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= I_rdata;
            pc_mem[wr_ptr]    <= fetch_pc;
        end
    end

`ifdef FETCH_PERF_EN
    // Saturating stall-cycle and redirect counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cycles <= '0;
            perf_redirects    <= '0;
        end else begin
            if (I_ren && I_stall && (perf_stall_cycles != '1))
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (redirect_valid && (perf_redirects != '1))
                perf_redirects <= perf_redirects + 16'd1;
        end
    end
`else
    assign perf_stall_cycles = '0;
    assign perf_redirects    = '0;
`endif

endmodule
